// File: rtl/lock_pkg.sv
// Shared types and constants for the combination-lock sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lock_pkg;

  // The numeric values are the estado codes seen on the board.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ENTRADA  = 4'd1,
    ST_ABERTO   = 4'd2,
    ST_ERRO     = 4'd3,
    ST_BLOQUEIO = 4'd4,
    ST_PROG     = 4'd5
  } lock_state_t;

  // Factory code 5,8,9,2,0,4; element 0 is the first digit entered.
  localparam int DEFAULT_LEN = 6;
  localparam logic [DEFAULT_LEN-1:0][3:0] DEFAULT_CODE =
    {4'd4, 4'd0, 4'd2, 4'd9, 4'd8, 4'd5};

  // Segment order {g,f,e,d,c,b,a}, active high.
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;
  localparam logic [6:0] GLYPH_A     = 7'b1110111;
  localparam logic [6:0] GLYPH_E     = 7'b1111001;
  localparam logic [6:0] GLYPH_L     = 7'b0111000;

  // Decimal font, element n draws digit n.
  localparam logic [9:0][6:0] DIGIT_FONT = {
    7'b1101111, 7'b1111111, 7'b0000111, 7'b1111101, 7'b1101101,
    7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
  };

  // Default digit for code position i; longer codes repeat the factory pattern.
  function automatic logic [3:0] default_digit(input int i);
    logic [2:0] k;
    k = 3'(i % DEFAULT_LEN);
    return DEFAULT_CODE[k];
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Maps a lock state plus last digit to the 7-segment pattern.
// Latency: combinational; the caller registers the result.
// Backpressure: none.
module seg7_decoder
  import lock_pkg::*;
(
  input  logic [3:0] estado,
  input  logic [3:0] digito,
  output logic [6:0] segs
);

  // Glyph per state; entry states show the digit, out-of-range digits go blank.
  always_comb begin
    segs = GLYPH_BLANK;
    case (estado)
      ST_ENTRADA, ST_PROG: if (digito <= 4'd9) segs = DIGIT_FONT[digito];
      ST_ABERTO:           segs = GLYPH_A;
      ST_ERRO:             segs = GLYPH_E;
      ST_BLOQUEIO:         segs = GLYPH_L;
      default:             segs = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/lock_sequencer.sv
// Digit-entry combination lock: attempt checking, fail count, lockout, optional reprogramming (LOCK_PROG_EN).
// Latency: all outputs registered, 1 clock after the insere rising-edge sample.
// Backpressure: none; digits arriving while not wanted (lockout, invalid BCD) are dropped.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int CODE_LEN       = 6,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       insere,
  input  logic [3:0] numero,
  input  logic       prog,
  output logic [3:0] estado,
  output logic [6:0] display,
  output logic       led,
  output logic       alarma
);

  // CODE_LEN must be at least 2: the first digit always moves to ENTRADA with idx=1.
  localparam int IW   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int FW   = $clog2(MAX_FAIL + 1);
  localparam int TMAX = (LOCKOUT_CYCLES > TIMEOUT_CYCLES) ? LOCKOUT_CYCLES : TIMEOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(CODE_LEN - 1);
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] LO_LAST   = TW'(LOCKOUT_CYCLES - 1);

  lock_state_t   state_q, state_n;
  logic [IW-1:0] idx_q, idx_n;
  logic          mis_q, mis_n;
  logic [FW-1:0] fails_q, fails_n;
  logic [TW-1:0] timer_q, timer_n;
  logic [3:0]    digit_q, digit_n;
  logic          insere_q;
  logic [6:0]    segs_n;
  logic          accept;
  logic          attempt_bad;
  logic [CODE_LEN-1:0][3:0] code;

`ifdef LOCK_PROG_EN
  logic [CODE_LEN-1:0][3:0] code_q, code_n, shadow_q, shadow_n;
  assign code = code_q;

  // Stored code and the shadow being programmed; reset restores the factory code.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CODE_LEN; i++) code_q[i] <= default_digit(i);
      shadow_q <= '0;
    end else begin
      code_q   <= code_n;
      shadow_q <= shadow_n;
    end
  end
`else
  logic unused_prog;
  assign unused_prog = prog;
  for (genvar g = 0; g < CODE_LEN; g++) begin : g_code
    assign code[g] = default_digit(g);
  end
`endif

  // A digit is one rising edge of insere carrying a valid BCD value.
  assign accept = insere & ~insere_q & (numero <= 4'd9);

  // Next-state and datapath decisions; timer restarts on any state change.
  always_comb begin
    state_n     = state_q;
    idx_n       = idx_q;
    mis_n       = mis_q;
    fails_n     = fails_q;
    digit_n     = digit_q;
    timer_n     = timer_q + 1'b1;
    attempt_bad = mis_q | (numero != code[idx_q]);
`ifdef LOCK_PROG_EN
    code_n      = code_q;
    shadow_n    = shadow_q;
`endif
    case (state_q)
      ST_IDLE, ST_ERRO: begin
        timer_n = '0;
        if (accept) begin
          state_n = ST_ENTRADA;
          idx_n   = IW'(1);
          mis_n   = (numero != code[0]);
          digit_n = numero;
        end
      end
      ST_ENTRADA: begin
        if (accept) begin
          timer_n = '0;
          digit_n = numero;
          if (idx_q == IDX_LAST) begin
            idx_n = '0;
            mis_n = 1'b0;
            if (!attempt_bad) begin
              state_n = ST_ABERTO;
              fails_n = '0;
            end else begin
              fails_n = fails_q + 1'b1;
              state_n = (fails_q == FAIL_LAST) ? ST_BLOQUEIO : ST_ERRO;
            end
          end else begin
            idx_n = idx_q + 1'b1;
            mis_n = attempt_bad;
          end
        end else if (timer_q == TO_LAST) begin
          state_n = ST_IDLE;
          idx_n   = '0;
          mis_n   = 1'b0;
        end
      end
      ST_ABERTO: begin
`ifdef LOCK_PROG_EN
        if (prog) begin
          state_n = ST_PROG;
          idx_n   = '0;
        end else
`endif
        if (accept || timer_q == TO_LAST) state_n = ST_IDLE;
      end
      ST_BLOQUEIO: begin
        if (timer_q == LO_LAST) begin
          state_n = ST_IDLE;
          fails_n = '0;
        end
      end
`ifdef LOCK_PROG_EN
      ST_PROG: begin
        if (accept) begin
          timer_n         = '0;
          digit_n         = numero;
          shadow_n[idx_q] = numero;
          if (idx_q == IDX_LAST) begin
            code_n  = shadow_n;
            state_n = ST_IDLE;
            idx_n   = '0;
          end else begin
            idx_n = idx_q + 1'b1;
          end
        end else if (timer_q == TO_LAST) begin
          state_n = ST_IDLE;
          idx_n   = '0;
        end
      end
`endif
      default: begin
        state_n = ST_IDLE;
        idx_n   = '0;
        mis_n   = 1'b0;
      end
    endcase
    if (state_n != state_q) timer_n = '0;
  end

  seg7_decoder u_seg7 (
    .estado (state_n),
    .digito (digit_n),
    .segs   (segs_n)
  );

  // Sequencer state and Moore outputs computed from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      mis_q    <= 1'b0;
      fails_q  <= '0;
      timer_q  <= '0;
      digit_q  <= '0;
      insere_q <= 1'b0;
      display  <= GLYPH_BLANK;
      led      <= 1'b0;
      alarma   <= 1'b0;
    end else begin
      state_q  <= state_n;
      idx_q    <= idx_n;
      mis_q    <= mis_n;
      fails_q  <= fails_n;
      timer_q  <= timer_n;
      digit_q  <= digit_n;
      insere_q <= insere;
      display  <= segs_n;
      led      <= (state_n == ST_ABERTO);
      alarma   <= (state_n == ST_BLOQUEIO);
    end
  end

  assign estado = state_q;

endmodule

// File: tb/tb_lock_sequencer.sv
module tb_lock_sequencer;

  localparam int CL = 6;
  localparam int MF = 3;
  localparam int LO = 20;
  localparam int TO = 30;
`ifdef LOCK_PROG_EN
  localparam bit PROG_EN = 1'b1;
`else
  localparam bit PROG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       insere = 1'b0;
  logic [3:0] numero = 4'd0;
  logic       prog = 1'b0;
  logic [3:0] estado;
  logic [6:0] display;
  logic       led;
  logic       alarma;

  int checks = 0;
  int errors = 0;

  lock_sequencer #(
    .CODE_LEN(CL), .MAX_FAIL(MF), .LOCKOUT_CYCLES(LO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .insere(insere), .numero(numero), .prog(prog),
    .estado(estado), .display(display), .led(led), .alarma(alarma)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int def_code[CL] = '{5, 8, 9, 2, 0, 4};
  int m_code[CL];
  int m_state, m_fails, m_cnt, m_last, nxt;
  bit m_ins_q, acc, ok;
  int att[$];
  int shd[$];

  function automatic logic [6:0] font(input int d);
    case (d)
      0: return 7'b0111111;  1: return 7'b0000110;  2: return 7'b1011011;
      3: return 7'b1001111;  4: return 7'b1100110;  5: return 7'b1101101;
      6: return 7'b1111101;  7: return 7'b0000111;  8: return 7'b1111111;
      9: return 7'b1101111;  default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] exp_disp(input int st, input int d);
    case (st)
      1, 5: return font(d);
      2: return 7'b1110111;
      3: return 7'b1111001;
      4: return 7'b0111000;
      default: return 7'b0000000;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state = 0; m_fails = 0; m_cnt = 0; m_last = 0; m_ins_q = 0;
      att.delete(); shd.delete();
      for (int i = 0; i < CL; i++) m_code[i] = def_code[i];
    end else begin
      acc = insere && !m_ins_q && (numero <= 4'd9);
      m_ins_q = insere;
      nxt = m_state;
      case (m_state)
        0, 3: if (acc) begin
          att.delete(); att.push_back(int'(numero)); m_last = numero; nxt = 1;
        end
        1: if (acc) begin
          att.push_back(int'(numero)); m_last = numero; m_cnt = 0;
          if (att.size() == CL) begin
            ok = 1;
            for (int i = 0; i < CL; i++) if (att[i] != m_code[i]) ok = 0;
            att.delete();
            if (ok) begin nxt = 2; m_fails = 0; end
            else begin m_fails++; nxt = (m_fails == MF) ? 4 : 3; end
          end
        end else begin
          m_cnt++;
          if (m_cnt == TO) begin nxt = 0; att.delete(); end
        end
        2: if (PROG_EN && prog) begin nxt = 5; shd.delete(); end
           else if (acc) nxt = 0;
           else begin m_cnt++; if (m_cnt == TO) nxt = 0; end
        4: begin m_cnt++; if (m_cnt == LO) begin nxt = 0; m_fails = 0; end end
        5: if (acc) begin
          shd.push_back(int'(numero)); m_last = numero; m_cnt = 0;
          if (shd.size() == CL) begin
            for (int i = 0; i < CL; i++) m_code[i] = shd[i];
            nxt = 0;
          end
        end else begin
          m_cnt++;
          if (m_cnt == TO) nxt = 0;
        end
        default: nxt = 0;
      endcase
      if (nxt != m_state) m_cnt = 0;
      m_state = nxt;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_estado",  estado,  m_state);
    chk("cyc_display", display, exp_disp(m_state, m_last));
    chk("cyc_led",     led,     (m_state == 2) ? 1 : 0);
    chk("cyc_alarma",  alarma,  (m_state == 4) ? 1 : 0);
  end

  // ---------------- stimulus ----------------
  int good[CL]  = '{5, 8, 9, 2, 0, 4};
  int wrong[CL] = '{5, 7, 8, 0, 0, 0};
  int newc[CL]  = '{1, 2, 3, 4, 5, 6};

  task automatic strobe(input int d);
    @(negedge clk); insere = 1'b1; numero = 4'(d);
    @(negedge clk); insere = 1'b0;
  endtask

  task automatic strobe_hold(input int d, input int n);
    @(negedge clk); insere = 1'b1; numero = 4'(d);
    repeat (n) @(negedge clk);
    insere = 1'b0;
  endtask

  task automatic attempt(input int s[CL]);
    for (int i = 0; i < CL; i++) strobe(s[i]);
  endtask

  initial begin
    int n;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_estado", estado, 0);
    chk("rst_display", display, 7'b0000000);
    chk("rst_led", led, 0);
    chk("rst_alarma", alarma, 0);
    reset = 1'b1;

    // correct code opens, first digit shown while entering
    strobe(5);
    chk("entry_estado", estado, 1);
    chk("entry_digit5", display, 7'b1101101);
    for (int i = 1; i < CL; i++) strobe(good[i]);
    chk("open_estado", estado, 2);
    chk("open_led", led, 1);
    chk("open_display", display, 7'b1110111);
    strobe(1);
    chk("relock_digit", estado, 0);

    // three wrong attempts lock out for exactly LO clocks
    attempt(wrong);
    chk("wrong1_estado", estado, 3);
    chk("wrong1_display", display, 7'b1111001);
    attempt(wrong);
    attempt(wrong);
    chk("lock_estado", estado, 4);
    chk("lock_display", display, 7'b0111000);
    n = 0;
    while (alarma && n < 200) begin n++; @(negedge clk); end
    chk("lock_cycles", n, LO);
    chk("lock_exit", estado, 0);
    attempt(wrong);
    attempt(wrong);
    chk("fails_cleared", estado, 3);
    attempt(good);
    chk("reopen", estado, 2);
    strobe(0);

    // invalid digit ignored, held strobe counts once
    strobe(5); strobe(8); strobe(10); strobe(9); strobe(2); strobe(0); strobe(4);
    chk("bcd10_ignored", estado, 2);
    strobe(0);
    strobe_hold(5, 5);
    for (int i = 1; i < CL; i++) strobe(good[i]);
    chk("held_once", estado, 2);

    // open then idle: relocks after TO clocks
    repeat (TO - 1) @(negedge clk);
    chk("open_pre_to", estado, 2);
    @(negedge clk);
    chk("open_to", estado, 0);

    // reprogramming
    attempt(good);
    @(negedge clk); prog = 1'b1;
    @(negedge clk); prog = 1'b0;
    chk("prog_entry", estado, PROG_EN ? 5 : 2);
`ifdef LOCK_PROG_EN
    attempt(newc);
    chk("prog_commit", estado, 0);
    attempt(good);
    chk("old_code_rejected", estado, 3);
    attempt(newc);
    chk("new_code_opens", estado, 2);
    strobe(0);
`else
    strobe(0);
    chk("prog_ignored_relock", estado, 0);
`endif

    // entry timeout keeps the fail count
    attempt(wrong);
    strobe(5); strobe(8);
    repeat (TO - 1) @(negedge clk);
    chk("entry_pre_to", estado, 1);
    @(negedge clk);
    chk("entry_to", estado, 0);
    attempt(wrong);
    chk("fails_kept_a", estado, 3);
    attempt(wrong);
    chk("fails_kept_lock", estado, 4);

    // asynchronous reset mid-lockout
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_alarma", alarma, 0);
    chk("arst_estado", estado, 0);
    chk("arst_display", display, 7'b0000000);
    @(negedge clk); reset = 1'b1;
    attempt(good);
    chk("post_reset_open", estado, 2);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/lock_sequencer.md
# lock_sequencer

Sequencing controller for the digit-entry combination lock. It accepts one BCD digit per `insere` strobe and compares each full attempt against a stored code. It counts failed attempts, enforces a lockout with alarm, and optionally lets an unlocked user reprogram the code. It drives the `estado`/`display`/`led` indicators seen by the board-level top.

## Interface
- `CODE_LEN`, default 6: digits per attempt/code.
- `MAX_FAIL`, default 3: consecutive failed attempts that trigger lockout.
- `LOCKOUT_CYCLES`, default 1000: lockout duration in clocks.
- `TIMEOUT_CYCLES`, default 500: inactivity limit in ENTRADA, ABERTO and PROG.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `insere`  in  1  digit strobe, level; a digit is accepted on the rising edge of `insere` only.
- `numero`  in  4  BCD digit, sampled with `insere`.
- `prog`  in  1  reprogram request, honoured only in ABERTO (see Configuration).
- `estado`  out  4  state encoding.
- `display`  out  7  7-segment pattern {g,f,e,d,c,b,a}, active high.
- `led`  out  1  unlocked indicator.
- `alarma`  out  1  lockout indicator.

## Operation
- Accept condition: `insere`=1 at a clock edge where the registered `insere_q`=0. A held `insere` yields exactly one digit.
- `numero`>9 is invalid: ignored in every state, with no timer restart and no index advance.
- States and `estado` codes: IDLE=0, ENTRADA=1, ABERTO=2, ERRO=3, BLOQUEIO=4, PROG=5.
- IDLE / ERRO, on a valid digit: compare it to code[0], set `mismatch` if it differs, set idx=1, go to ENTRADA.
- ENTRADA, on a valid digit: compare it to code[idx], OR the result into `mismatch`, increment idx. No early abort: all CODE_LEN digits are always collected.
- On the CODE_LEN-th digit:
  - `mismatch`=0: go to ABERTO and clear `fails`.
  - Otherwise: `fails`+1. If the new value equals MAX_FAIL, go to BLOQUEIO; else go to ERRO.
- ENTRADA timeout (TIMEOUT_CYCLES clocks with no valid digit): go to IDLE, `fails` unchanged.
- ABERTO:
  - `led`=1.
  - A valid digit or the timeout relocks to IDLE; the digit is discarded.
  - `prog` goes to PROG.
  - `prog` together with a digit in the same cycle: `prog` wins.
- BLOQUEIO:
  - `alarma`=1 and all digits are ignored.
  - After LOCKOUT_CYCLES clocks: go to IDLE and clear `fails`.
- PROG:
  - Valid digits fill a shadow register.
  - After the CODE_LEN-th digit, the shadow is committed atomically to the code and the state goes to IDLE.
  - Timeout goes to IDLE with the code unchanged.
- Display patterns:
  - IDLE: blank, 0000000.
  - ENTRADA/PROG: last accepted digit in standard decimal font.
  - ABERTO: "A", 1110111.
  - ERRO: "E", 1111001.
  - BLOQUEIO: "L", 0111000.
- `fails` width is $clog2(MAX_FAIL+1). Timers are sized for max(LOCKOUT_CYCLES, TIMEOUT_CYCLES) and never wrap.

## Timing
- All outputs are registered (Moore) and update on the same edge that accepts the digit or completes the timer. Latency is 1 clock from the `insere` rising-edge sample.
- Reset values:
  - state IDLE, `estado`=0, `display`=0000000, `led`=0, `alarma`=0.
  - `fails`=0, idx=0, timers=0, `insere_q`=0.
  - code = DEFAULT_CODE.
- Reset asserted mid-operation (including BLOQUEIO or PROG): outputs clear immediately (asynchronous), any programmed code reverts to default, and a partial PROG is discarded.
- The inactivity timer restarts on every valid accepted digit and on every state entry.
- Lockout is exact: `alarma` is high for LOCKOUT_CYCLES clocks, then the state is IDLE on the next edge.

## Configuration
- `LOCK_PROG_EN` defined:
  - The PROG state, shadow register and `prog` handling are built.
  - The code is a register initialised to DEFAULT_CODE.
- `LOCK_PROG_EN` undefined:
  - `prog` is ignored and state 5 is unreachable.
  - The code is the constant DEFAULT_CODE, with no code/shadow flops.

## Structure
- Shared package `lock_pkg`:
  - State enum with the `estado` codes above.
  - DEFAULT_CODE = 5,8,9,2,0,4.
  - Glyph constants: blank, A, E, L.
  - Digit font table.
- One sub-module, `seg7_decoder`: combinational digit/glyph to 7-segment. Its output is registered in `lock_sequencer`.

## Test plan
Bench parameters: LOCKOUT_CYCLES=20, TIMEOUT_CYCLES=30.
- Reset, then strobe 5,8,9,2,0,4 → `estado`=2, `led`=1, `display`=1110111.
- Strobe 5,7,8,0,0,0 → `estado`=3, `display`=1111001. Two more wrong attempts → `estado`=4 and `alarma`=1 for exactly 20 clocks, then `estado`=0 with `fails` cleared.
- Strobe 5,8,10,9,2,0,4 → the 10 is ignored and the lock opens. Holding `insere` high for 5 clocks counts as one digit.
- Strobe 5,8, then idle 30 clocks → `estado`=0 and `fails` unchanged. Open, then idle 30 clocks → relock to IDLE.
- (`LOCK_PROG_EN`) Open, pulse `prog`, strobe 1,2,3,4,5,6 → IDLE. Attempt 5,8,9,2,0,4 → ERRO; attempt 1,2,3,4,5,6 → ABERTO.
- Assert `reset` mid-BLOQUEIO → `alarma`=0 and `estado`=0 immediately. After release, 5,8,9,2,0,4 opens the lock.
